pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS pipeline. It consumes the EX-stage branch decision (BranchValid from the condition-check stage) and ID/EX register usage. It produces the PC/IF-ID write enables and the IF-ID/ID-EX flush controls. It also owns the occupancy tracker for the multi-cycle mult/div unit, plus stall and flush performance counters.

Parameters:
MDU_LAT, 32, cycles the mult/div unit is busy after a start (legal range 2..63)
CNT_W, 16, width of the saturating stall/flush performance counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
ID_Rs  in  5  rs field of instruction in ID
ID_Rt  in  5  rt field of instruction in ID
ID_UseRs  in  1  ID instruction reads rs
ID_UseRt  in  1  ID instruction reads rt
ID_IsMDU  in  1  ID instruction is mult/multu/div/divu
ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
EX_Rd  in  5  destination register of instruction in EX
EX_RegWrite  in  1  EX instruction writes a GPR
EX_MemRead  in  1  EX instruction is a load (MemWBSrc)
EX_BranchValid  in  1  resolved taken branch/jump in EX
PC_Write_En  out  1  PC may update
PC_Src_Branch  out  1  PC loads branch target this cycle
IFID_Write_En  out  1  IF/ID register may update
IFID_Flush  out  1  clear IF/ID to nop
IDEX_Flush  out  1  insert bubble into ID/EX
MDU_Start  out  1  one-cycle start pulse to mult/div unit
MDU_Busy  out  1  mult/div unit occupied
Stall_Count  out  CNT_W  saturating count of stall cycles
Flush_Count  out  CNT_W  saturating count of branch flushes

Behaviour:
- State registers: mode {RUN, MDU_WAIT}, 6-bit countdown mdu_cnt, Stall_Count, Flush_Count. All outputs except the counters and MDU_Busy are combinational from the registered state and the current inputs.
- Reset (sync, takes priority over all other events): mode=RUN, mdu_cnt=0, counters=0. With inputs idle (all 0), the outputs are PC_Write_En=1, IFID_Write_En=1, all other outputs 0.
- load_use = EX_MemRead & EX_RegWrite & (EX_Rd!=0) & ((ID_UseRs & ID_Rs==EX_Rd) | (ID_UseRt & ID_Rt==EX_Rd)).
- mdu_hazard = (mode==MDU_WAIT) & (ID_IsMDU | ID_ReadsHiLo).
- Priority per cycle:
  - 1. EX_BranchValid: PC_Write_En=1, PC_Src_Branch=1, IFID_Write_En=1, IFID_Flush=1, IDEX_Flush=1. Any load-use or MDU hazard is ignored because the ID instruction is squashed. MDU_Start=0.
  - 2. load_use | mdu_hazard: PC_Write_En=0, IFID_Write_En=0, IDEX_Flush=1, IFID_Flush=0.
  - 3. Otherwise: normal advance (PC_Write_En=1, IFID_Write_En=1, flushes 0).
- MDU_Start = ID_IsMDU & the instruction advances (case 3 only).
- MDU_Busy = (mode==MDU_WAIT).
- RUN + MDU_Start: next mode=MDU_WAIT, mdu_cnt=MDU_LAT. MDU_Busy is high for exactly MDU_LAT cycles after the start cycle.
- MDU_WAIT: mdu_cnt decrements each cycle. When mdu_cnt==1, next mode=RUN and mdu_cnt=0. A HiLo reader held in ID advances in the first cycle with MDU_Busy=0.
- A branch flush does not abort an in-flight MDU operation: countdown continues.
- Stall_Count increments on each cycle of case 2. Flush_Count increments on each cycle of case 1. Both saturate at all-ones with no wrap.
- A load-use stall lasts exactly one cycle: the bubble removes the hazard in the next cycle.
- A reset asserted mid-MDU_WAIT clears mode, mdu_cnt and Busy on that edge. The MDU datapath is reset separately.

Test Plan:
- Reset held 2 cycles, all inputs 0 -> PC_Write_En=1, IFID_Write_En=1, flushes=0, MDU_Busy=0, Stall_Count=0, Flush_Count=0.
- EX: lw with EX_Rd=8, EX_MemRead=1, EX_RegWrite=1; ID_Rs=8, ID_UseRs=1 -> exactly one cycle of PC_Write_En=0, IFID_Write_En=0, IDEX_Flush=1, then advance; Stall_Count=1. Repeat with EX_Rd=0 -> no stall.
- Same load-use condition plus EX_BranchValid=1 in the same cycle -> PC_Src_Branch=1, IFID_Flush=1, IDEX_Flush=1, PC_Write_En=1; Stall_Count unchanged; Flush_Count=1.
- MDU_LAT=4: ID_IsMDU=1 at cycle 0 -> MDU_Start pulse at cycle 0; MDU_Busy=1 in cycles 1-4; mfhi presented at cycle 1 stalls cycles 1-4 and advances at cycle 5; Stall_Count=4.
- MDU_LAT=4: start at cycle 0, reset at cycle 2 -> MDU_Busy=0 from cycle 3; a waiting mfhi advances at cycle 3.
- CNT_W=4: force 20 consecutive load-use stall cycles -> Stall_Count saturates at 15 and holds.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use and mult/div
// interlocks, branch squash, mult/div occupancy tracking and perf counters.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | mult/div unit idle, HiLo readers and new mult/div may advance
// MDU_WAIT | mult/div unit busy, mult/div and HiLo instructions are held in ID
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic             ID_IsMDU,
    input  logic             ID_ReadsHiLo,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic             EX_BranchValid,
    output logic             PC_Write_En,
    output logic             PC_Src_Branch,
    output logic             IFID_Write_En,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             MDU_Start,
    output logic             MDU_Busy,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    typedef enum logic {RUN, MDU_WAIT} mode_t;

    localparam logic [5:0] MDU_LOAD = MDU_LAT[5:0];

    mode_t      mode;
    logic [5:0] mdu_cnt;
    logic       load_use;
    logic       mdu_hazard;
    logic       flush_case;
    logic       stall_case;

    assign load_use   = EX_MemRead & EX_RegWrite & (EX_Rd != 5'd0) &
                        ((ID_UseRs & (ID_Rs == EX_Rd)) | (ID_UseRt & (ID_Rt == EX_Rd)));
    assign mdu_hazard = (mode == MDU_WAIT) & (ID_IsMDU | ID_ReadsHiLo);

    // A taken branch squashes the ID instruction, so its hazards are moot.
    assign flush_case = EX_BranchValid;
    assign stall_case = ~EX_BranchValid & (load_use | mdu_hazard);

    assign PC_Write_En   = ~stall_case;
    assign PC_Src_Branch = flush_case;
    assign IFID_Write_En = ~stall_case;
    assign IFID_Flush    = flush_case;
    assign IDEX_Flush    = flush_case | stall_case;
    assign MDU_Start     = ID_IsMDU & ~flush_case & ~stall_case;
    assign MDU_Busy      = (mode == MDU_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode        <= RUN;
            mdu_cnt     <= 6'd0;
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            case (mode)
                RUN: begin
                    if (MDU_Start) begin
                        mode    <= MDU_WAIT;
                        mdu_cnt <= MDU_LOAD;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_cnt == 6'd1) begin
                        mode    <= RUN;
                        mdu_cnt <= 6'd0;
                    end else begin
                        mdu_cnt <= mdu_cnt - 6'd1;
                    end
                end
                default: begin
                    mode    <= RUN;
                    mdu_cnt <= 6'd0;
                end
            endcase

            // Counters saturate rather than wrap.
            if (stall_case && (Stall_Count != {CNT_W{1'b1}}))
                Stall_Count <= Stall_Count + CNT_W'(1);
            if (flush_case && (Flush_Count != {CNT_W{1'b1}}))
                Flush_Count <= Flush_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MDU_LAT=4, CNT_W=4) with an expected-result queue.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ID_Rs, ID_Rt, EX_Rd;
    logic       ID_UseRs, ID_UseRt, ID_IsMDU, ID_ReadsHiLo;
    logic       EX_RegWrite, EX_MemRead, EX_BranchValid;
    logic       PC_Write_En, PC_Src_Branch, IFID_Write_En, IFID_Flush, IDEX_Flush;
    logic       MDU_Start, MDU_Busy;
    logic [3:0] Stall_Count, Flush_Count;

    pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_IsMDU(ID_IsMDU), .ID_ReadsHiLo(ID_ReadsHiLo),
        .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_BranchValid(EX_BranchValid),
        .PC_Write_En(PC_Write_En), .PC_Src_Branch(PC_Src_Branch),
        .IFID_Write_En(IFID_Write_En), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .MDU_Start(MDU_Start), .MDU_Busy(MDU_Busy),
        .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    always #5 clk = ~clk;

    // ctl = {PC_Write_En, PC_Src_Branch, IFID_Write_En, IFID_Flush, IDEX_Flush, MDU_Start, MDU_Busy}
    localparam logic [6:0] ADV   = 7'b1010000;
    localparam logic [6:0] STALL = 7'b0000100;
    localparam logic [6:0] BR    = 7'b1111100;
    localparam logic [6:0] START = 7'b0000010;
    localparam logic [6:0] BUSY  = 7'b0000001;

    typedef struct {
        string      tag;
        logic [6:0] ctl;
        logic [3:0] stall;
        logic [3:0] flush;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] tally_stall = 4'd0;
    logic [3:0] tally_flush = 4'd0;

    task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                         input logic mdu, input logic hilo, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic br);
        ID_Rs = rs; ID_UseRs = urs; ID_Rt = rt; ID_UseRt = urt;
        ID_IsMDU = mdu; ID_ReadsHiLo = hilo;
        EX_Rd = rd; EX_RegWrite = rw; EX_MemRead = mr; EX_BranchValid = br;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected counters are the tally of earlier cycles; this cycle's event lands at the next edge.
    task automatic step(input string tag, input logic [6:0] ctl, input logic is_stall,
                        input logic is_flush, input logic is_reset);
        exp_t e;
        exp_t got;
        logic [6:0] obs;
        sb.push_back('{tag, ctl, tally_stall, tally_flush});
        @(negedge clk);
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            obs = {PC_Write_En, PC_Src_Branch, IFID_Write_En, IFID_Flush, IDEX_Flush,
                   MDU_Start, MDU_Busy};
            vectors++;
            assert (obs === got.ctl) else begin
                miscompares++;
                $error("FAIL %s ctl observed=%b expected=%b", got.tag, obs, got.ctl);
            end
            vectors++;
            assert (Stall_Count === got.stall) else begin
                miscompares++;
                $error("FAIL %s stall_count observed=%0d expected=%0d", got.tag, Stall_Count, got.stall);
            end
            vectors++;
            assert (Flush_Count === got.flush) else begin
                miscompares++;
                $error("FAIL %s flush_count observed=%0d expected=%0d", got.tag, Flush_Count, got.flush);
            end
        end
        if (is_reset) begin
            tally_stall = 4'd0;
            tally_flush = 4'd0;
        end else begin
            if (is_stall && tally_stall != 4'hF) tally_stall = tally_stall + 4'd1;
            if (is_flush && tally_flush != 4'hF) tally_flush = tally_flush + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("reset_idle", ADV, 1'b0, 1'b0, 1'b0);

        // load-use on rs: one stall, then the bubble clears EX
        drive(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step("lu_rs_stall", STALL, 1'b1, 1'b0, 1'b0);
        drive(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("lu_rs_advance", ADV, 1'b0, 1'b0, 1'b0);
        drive(5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        step("lu_rd_zero", ADV, 1'b0, 1'b0, 1'b0);
        drive(5'd3, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        step("lu_rt_stall", STALL, 1'b1, 1'b0, 1'b0);
        drive(5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        step("lu_unused_regs", ADV, 1'b0, 1'b0, 1'b0);
        drive(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
        step("lu_no_regwrite", ADV, 1'b0, 1'b0, 1'b0);
        drive(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        step("lu_blocks_mdu_start", STALL, 1'b1, 1'b0, 1'b0);

        // load-use and branch in the same cycle: branch wins
        drive(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1);
        step("lu_plus_branch", BR, 1'b0, 1'b1, 1'b0);
        idle();
        step("after_branch", ADV, 1'b0, 1'b0, 1'b0);

        // mult at cycle 0, mfhi held through cycles 1-4, advances at cycle 5
        drive(5'd4, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("mdu_start", ADV | START, 1'b0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) step($sformatf("mfhi_wait_c%0d", c), STALL | BUSY, 1'b1, 1'b0, 1'b0);
        step("mfhi_advance", ADV, 1'b0, 1'b0, 1'b0);
        idle();
        step("mdu_idle", ADV, 1'b0, 1'b0, 1'b0);

        // branch during MDU_WAIT squashes the reader but the countdown keeps running
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("mdu_start2", ADV | START, 1'b0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        step("branch_in_wait", BR | BUSY, 1'b0, 1'b1, 1'b0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 2; c <= 4; c++) step($sformatf("wait2_c%0d", c), STALL | BUSY, 1'b1, 1'b0, 1'b0);
        step("wait2_advance", ADV, 1'b0, 1'b0, 1'b0);

        // reset in the middle of MDU_WAIT
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("rst_mdu_start", ADV | START, 1'b0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("rst_wait_c1", STALL | BUSY, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step("rst_wait_c2", STALL | BUSY, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step("rst_mfhi_advance", ADV, 1'b0, 1'b0, 1'b0);

        // 20 stall cycles: Stall_Count saturates at 15
        drive(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) step($sformatf("sat_c%0d", c), STALL, 1'b1, 1'b0, 1'b0);
        idle();
        step("sat_hold", ADV, 1'b0, 1'b0, 1'b0);
        step("sat_hold2", ADV, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
